// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared constants and binary-to-BCD helper for clock stages.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    localparam int   SEC_MODULUS  = 60;
    localparam int   MIN_MODULUS  = 60;
    localparam int   HR24_MODULUS = 24;
    localparam int   HR12_MODULUS = 12;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Two-digit BCD of a value below 100; only loads and constants use it.
    function automatic logic [7:0] to_bcd(input logic [15:0] value);
        return {4'((value / 16'd10) % 16'd10), 4'(value % 16'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One mod-10 up/down BCD digit with step, carry/borrow, force.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       step_in,
    input  logic       up_in,
    input  logic       force_in,
    input  logic [3:0] force_val_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Carry (up, 9->0) and borrow (down, 0->9) share one output.
    assign carry_out = step_in && (up_in ? (digit_q == 4'd9) : (digit_q == 4'd0));
    assign digit_out = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (force_in) begin
            digit_d = force_val_in;
        end else if (step_in) begin
            if (up_in) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_modn.sv
`default_nettype none
// ============================================================================
//  Module      : counter_modn
//  Description : Modulo-N up/down counter with clear, checked load, wrap pulse
//                and a lock-step BCD copy of the count.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_modn
    import clock_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MODULUS    = 60,
    parameter int BCD_DIGITS = 2
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    en_in,
    input  logic                    up_in,
    input  logic                    clr_in,
    input  logic                    load_in,
    input  logic [WIDTH-1:0]        load_val_in,
    output logic [WIDTH-1:0]        count_out,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    wrap_out,
    output logic                    tc_out,
    output logic                    load_err_out
);

    localparam int                  BCD_W     = 4 * BCD_DIGITS;
    localparam logic [WIDTH-1:0]    C_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [BCD_W-1:0]    C_MAX_BCD = BCD_W'(to_bcd(16'(MODULUS - 1)));

    logic [WIDTH-1:0]  count_q,    count_d;
    logic              wrap_q,     wrap_d;
    logic              load_err_q, load_err_d;

    logic              bcd_step;
    logic              bcd_force;
    logic [BCD_W-1:0]  bcd_force_val;
    logic [BCD_DIGITS-1:0] digit_carry;
    logic              msd_carry_unused;

    always_comb begin
        count_d       = count_q;
        wrap_d        = 1'b0;
        load_err_d    = 1'b0;
        bcd_step      = 1'b0;
        bcd_force     = 1'b0;
        bcd_force_val = '0;
        if (clr_in) begin
            count_d   = '0;
            bcd_force = 1'b1;
        end else if (load_in) begin
            if (load_val_in <= C_MAX) begin
                count_d       = load_val_in;
                bcd_force     = 1'b1;
                bcd_force_val = BCD_W'(to_bcd(16'(load_val_in)));
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en_in) begin
            // Wraps force the BCD digits; ordinary steps ripple through them.
            if (up_in) begin
                if (count_q == C_MAX) begin
                    count_d   = '0;
                    wrap_d    = 1'b1;
                    bcd_force = 1'b1;
                end else begin
                    count_d  = count_q + WIDTH'(1);
                    bcd_step = 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d       = C_MAX;
                    wrap_d        = 1'b1;
                    bcd_force     = 1'b1;
                    bcd_force_val = C_MAX_BCD;
                end else begin
                    count_d  = count_q - WIDTH'(1);
                    bcd_step = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    generate
        for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
            logic digit_step;
            if (i == 0) begin : g_lsd
                assign digit_step = bcd_step;
            end else begin : g_upper
                assign digit_step = digit_carry[i-1];
            end

            bcd_digit u_digit (
                .clk_in       (clk_in),
                .reset_in     (reset_in),
                .step_in      (digit_step),
                .up_in        (up_in),
                .force_in     (bcd_force),
                .force_val_in (bcd_force_val[4*i +: 4]),
                .digit_out    (bcd_out[4*i +: 4]),
                .carry_out    (digit_carry[i])
            );
        end
    endgenerate

    // The count never steps past MODULUS-1, so the top digit cannot carry.
    assign msd_carry_unused = digit_carry[BCD_DIGITS-1];

    assign count_out    = count_q;
    assign wrap_out     = wrap_q;
    assign load_err_out = load_err_q;
    // Gated by reset so every output reads 0 while reset is held.
    assign tc_out       = reset_in &&
                          ((up_in && (count_q == C_MAX)) || (!up_in && (count_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_counter_modn.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_modn
//  Description : Directed self-checking bench for counter_modn (60, 24, 12).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_modn;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_en, a_up, a_clr, a_load;
    logic [7:0] a_val;
    logic [7:0] a_count, a_bcd;
    logic       a_wrap, a_tc, a_lerr;

    logic       s_en, s_up;
    logic [4:0] b_count;
    logic [7:0] b_bcd, c_count, c_bcd;
    logic       b_wrap, b_tc, b_lerr, c_wrap, c_tc, c_lerr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_modn #(.WIDTH(8), .MODULUS(60), .BCD_DIGITS(2)) u_dut60 (
        .clk_in(clk), .reset_in(reset_n), .en_in(a_en), .up_in(a_up),
        .clr_in(a_clr), .load_in(a_load), .load_val_in(a_val),
        .count_out(a_count), .bcd_out(a_bcd), .wrap_out(a_wrap),
        .tc_out(a_tc), .load_err_out(a_lerr)
    );

    counter_modn #(.WIDTH(5), .MODULUS(24), .BCD_DIGITS(2)) u_dut24 (
        .clk_in(clk), .reset_in(reset_n), .en_in(s_en), .up_in(s_up),
        .clr_in(1'b0), .load_in(1'b0), .load_val_in(5'd0),
        .count_out(b_count), .bcd_out(b_bcd), .wrap_out(b_wrap),
        .tc_out(b_tc), .load_err_out(b_lerr)
    );

    counter_modn #(.WIDTH(8), .MODULUS(12), .BCD_DIGITS(2)) u_dut12 (
        .clk_in(clk), .reset_in(reset_n), .en_in(s_en), .up_in(s_up),
        .clr_in(1'b0), .load_in(1'b0), .load_val_in(8'd0),
        .count_out(c_count), .bcd_out(c_bcd), .wrap_out(c_wrap),
        .tc_out(c_tc), .load_err_out(c_lerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk60(input string tag, input logic [7:0] cnt, input logic [7:0] bcd,
                         input logic wrap, input logic tc, input logic lerr);
        chk({tag, ".count"}, 32'(a_count), 32'(cnt));
        chk({tag, ".bcd"},   32'(a_bcd),   32'(bcd));
        chk({tag, ".wrap"},  32'(a_wrap),  32'(wrap));
        chk({tag, ".tc"},    32'(a_tc),    32'(tc));
        chk({tag, ".lerr"},  32'(a_lerr),  32'(lerr));
    endtask

    function automatic logic [7:0] ref_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        int  m24, m12;
        logic w24, w12;

        reset_n = 1'b0;
        a_en = 1'b0; a_up = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_val = 8'd0;
        s_en = 1'b0; s_up = 1'b1;
        step(); step();
        // up_in=0 at count 0 would raise tc if it were not gated by reset
        chk60("reset_init", 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Reset mid-count at 37, en held through release
        a_load = 1'b1; a_val = 8'd37;
        step();
        chk60("load37", 8'd37, 8'h37, 1'b0, 1'b0, 1'b0);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        chk60("async_reset", 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        chk60("reset_held", 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        chk60("after_release", 8'd1, 8'h01, 1'b0, 1'b0, 1'b0);

        // Up wrap
        a_en = 1'b0; a_load = 1'b1; a_val = 8'd58;
        step();
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
        #1;
        chk60("up58", 8'd58, 8'h58, 1'b0, 1'b0, 1'b0);
        step(); chk60("up59", 8'd59, 8'h59, 1'b0, 1'b1, 1'b0);
        step(); chk60("up0",  8'd0,  8'h00, 1'b1, 1'b0, 1'b0);
        step(); chk60("up1",  8'd1,  8'h01, 1'b0, 1'b0, 1'b0);

        // Down wrap
        a_en = 1'b0; a_load = 1'b1; a_val = 8'd1;
        step();
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        step(); chk60("dn0",  8'd0,  8'h00, 1'b0, 1'b1, 1'b0);
        step(); chk60("dn59", 8'd59, 8'h59, 1'b1, 1'b0, 1'b0);
        step(); chk60("dn58", 8'd58, 8'h58, 1'b0, 1'b0, 1'b0);
        // BCD borrow across the tens digit
        a_en = 1'b0; a_load = 1'b1; a_val = 8'd20;
        step();
        a_load = 1'b0; a_en = 1'b1;
        step(); chk60("dn19", 8'd19, 8'h19, 1'b0, 1'b0, 1'b0);
        a_up = 1'b1;
        step(); chk60("up20", 8'd20, 8'h20, 1'b0, 1'b0, 1'b0);

        // Load range check
        a_en = 1'b0; a_load = 1'b1; a_val = 8'd59;
        step(); chk60("ld59",  8'd59, 8'h59, 1'b0, 1'b1, 1'b0);
        a_val = 8'd60;
        step(); chk60("ld60",  8'd59, 8'h59, 1'b0, 1'b1, 1'b1);
        a_val = 8'd255;
        step(); chk60("ld255", 8'd59, 8'h59, 1'b0, 1'b1, 1'b1);
        a_load = 1'b0;
        step(); chk60("ld_idle", 8'd59, 8'h59, 1'b0, 1'b1, 1'b0);

        // Priority: clear beats load and enable, even at the wrap point
        a_clr = 1'b1; a_load = 1'b1; a_en = 1'b1; a_val = 8'd200;
        step(); chk60("clr_prio", 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        a_clr = 1'b0; a_val = 8'd20;
        step(); chk60("ld20", 8'd20, 8'h20, 1'b0, 1'b0, 1'b0);
        a_clr = 1'b1; a_val = 8'd10;
        step(); chk60("clr_all", 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        a_clr = 1'b0;
        step(); chk60("ld_over_en", 8'd10, 8'h10, 1'b0, 1'b0, 1'b0);
        a_load = 1'b0; a_en = 1'b0;

        // Sweep MOD-24 and MOD-12 against a mod-N model
        m24 = 0; m12 = 0;
        for (int i = 0; i < 200; i++) begin
            s_en = 1'b1;
            s_up = (i < 100);
            if (s_up) begin
                w24 = (m24 == 23); m24 = w24 ? 0  : m24 + 1;
                w12 = (m12 == 11); m12 = w12 ? 0  : m12 + 1;
            end else begin
                w24 = (m24 == 0);  m24 = w24 ? 23 : m24 - 1;
                w12 = (m12 == 0);  m12 = w12 ? 11 : m12 - 1;
            end
            step();
            chk("m24.count", 32'(b_count), 32'(m24));
            chk("m24.bcd",   32'(b_bcd),   32'(ref_bcd(m24)));
            chk("m24.wrap",  32'(b_wrap),  32'(w24));
            chk("m12.count", 32'(c_count), 32'(m12));
            chk("m12.bcd",   32'(c_bcd),   32'(ref_bcd(m12)));
            chk("m12.wrap",  32'(c_wrap),  32'(w12));
        end
        s_en = 1'b0;
        step();
        chk("m24.wrap_idle", 32'(b_wrap), 32'(0));
        chk("m12.lerr",      32'(c_lerr), 32'(0));
        chk("m24.lerr",      32'(b_lerr), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
